// File: rtl/can_param_fifo_pkg.sv
// Shared CAN definitions: frame record width/type and the wrap-around pointer helper
// used by the message FIFO and its pointer sub-module.
package can_pkg;

  localparam int CAN_FRAME_W = 128;

  typedef logic [CAN_FRAME_W-1:0] can_frame_t;

  // Wraps with an explicit compare so depths that are not a power of two work.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/can_param_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer for the CAN message FIFO; reset and clear both return it to 0.
module can_wrap_ptr
  import can_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= PTR_W'(next_ptr(32'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/can_param_fifo.sv
// Single-clock show-ahead message FIFO for CAN TX/RX queues with occupancy and flags.
// Build option CAN_FIFO_DROP_OLDEST_EN: a write while full overwrites the oldest entry.
module can_param_fifo
  import can_pkg::*;
#(
  parameter int DATA_W    = CAN_FRAME_W,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_w_en,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic              i_r_en,
  output logic [DATA_W-1:0] o_r_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  w_ptr;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_acc;
  logic              wr_acc;
  logic              drop_oldest;
  logic              busy_clear;

  assign busy_clear = i_reset || i_flush;

  assign o_count        = count;
  assign o_full         = (count == CNT_W'(DEPTH));
  assign o_empty        = (count == '0);
  assign o_almost_full  = (count >= CNT_W'(AF_THRESH));
  assign o_almost_empty = (count <= CNT_W'(AE_THRESH));
  assign o_r_data       = o_empty ? '0 : mem[r_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  assign rd_acc = i_r_en && !o_empty;
  assign wr_acc = i_w_en && (!o_full || rd_acc);

`ifdef CAN_FIFO_DROP_OLDEST_EN
  assign drop_oldest = i_w_en && o_full && !rd_acc;
`else
  assign drop_oldest = 1'b0;
`endif

  can_wrap_ptr #(.DEPTH(DEPTH)) u_w_ptr (
    .clk   (i_sys_clk),
    .reset (i_reset),
    .clear (i_flush),
    .inc   (wr_acc || drop_oldest),
    .ptr   (w_ptr)
  );

  can_wrap_ptr #(.DEPTH(DEPTH)) u_r_ptr (
    .clk   (i_sys_clk),
    .reset (i_reset),
    .clear (i_flush),
    .inc   (rd_acc || drop_oldest),
    .ptr   (r_ptr)
  );

  // NOTE: storage has no reset; o_r_data is masked by o_empty so stale entries never leak out.
  always_ff @(posedge i_sys_clk) begin
    if (!busy_clear && (wr_acc || drop_oldest)) begin
      mem[w_ptr] <= i_w_data;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (busy_clear) begin
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
      o_overflow  <= i_w_en && !wr_acc;
      o_underflow <= i_r_en && !rd_acc;
    end
  end

endmodule

// File: tb/tb_can_param_fifo.sv
// Randomised plus directed bench for can_param_fifo against a queue-based reference model.
module tb_can_param_fifo;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 3;
  localparam int AF     = 2;
  localparam int AE     = 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              i_sys_clk = 1'b0;
  logic              i_reset;
  logic              i_flush;
  logic              i_w_en;
  logic [DATA_W-1:0] i_w_data;
  logic              i_r_en;
  logic [DATA_W-1:0] o_r_data;
  logic [CNT_W-1:0]  o_count;
  logic              o_full;
  logic              o_empty;
  logic              o_almost_full;
  logic              o_almost_empty;
  logic              o_overflow;
  logic              o_underflow;

  always #5 i_sys_clk = ~i_sys_clk;

  can_param_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .i_sys_clk      (i_sys_clk),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_w_en         (i_w_en),
    .i_w_data       (i_w_data),
    .i_r_en         (i_r_en),
    .o_r_data       (o_r_data),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model_q[$];
  bit                model_ovf;
  bit                model_unf;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: a bounded queue of frames, updated once per clock edge.
  task automatic model_edge();
    bit can_read;
    bit can_write;
    if (i_reset || i_flush) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      can_read  = i_r_en && (model_q.size() > 0);
      can_write = i_w_en && ((model_q.size() < DEPTH) || can_read);
      if (can_read) void'(model_q.pop_front());
      if (can_write) begin
        model_q.push_back(i_w_data);
      end else if (i_w_en) begin
`ifdef CAN_FIFO_DROP_OLDEST_EN
        void'(model_q.pop_front());
        model_q.push_back(i_w_data);
`endif
      end
      model_ovf = i_w_en && !can_write;
      model_unf = i_r_en && !can_read;
    end
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    check("count", 128'(o_count), 128'(n));
    check("empty", 128'(o_empty), 128'(n == 0));
    check("full", 128'(o_full), 128'(n == DEPTH));
    check("almost_full", 128'(o_almost_full), 128'(n >= AF));
    check("almost_empty", 128'(o_almost_empty), 128'(n <= AE));
    check("r_data", o_r_data, (n == 0) ? 128'd0 : model_q[0]);
    check("overflow", 128'(o_overflow), 128'(model_ovf));
    check("underflow", 128'(o_underflow), 128'(model_unf));
  endtask

  task automatic step(input bit rst, input bit fl, input bit we, input bit re,
                      input logic [DATA_W-1:0] d);
    i_reset  = rst;
    i_flush  = fl;
    i_w_en   = we;
    i_r_en   = re;
    i_w_data = d;
    @(posedge i_sys_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  logic [DATA_W-1:0] fa, fb, fc, fd;

  initial begin
    fa = {4{32'hA0A0_0001}};
    fb = {4{32'hB0B0_0002}};
    fc = {4{32'hC0C0_0003}};
    fd = {4{32'hD0D0_0004}};

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("rst_empty", 128'(o_empty), 128'd1);
    check("rst_full", 128'(o_full), 128'd0);
    check("rst_count", 128'(o_count), 128'd0);
    check("rst_r_data", o_r_data, 128'd0);
    check("rst_almost_empty", 128'(o_almost_empty), 128'd1);
    check("rst_almost_full", 128'(o_almost_full), 128'd0);

    // Fill to full, overflow, drain in order
    step(1'b0, 1'b0, 1'b1, 1'b0, fa);
    step(1'b0, 1'b0, 1'b1, 1'b0, fb);
    check("t1_af_at_2", 128'(o_almost_full), 128'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, fc);
    check("t1_full_at_3", 128'(o_full), 128'd1);
`ifndef CAN_FIFO_DROP_OLDEST_EN
    step(1'b0, 1'b0, 1'b1, 1'b0, fd);
    check("t1_overflow", 128'(o_overflow), 128'd1);
    idle();
    check("t1_overflow_clear", 128'(o_overflow), 128'd0);
    check("t1_head_a", o_r_data, fa);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("t1_head_b", o_r_data, fb);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("t1_head_c", o_r_data, fc);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
`else
    // Dropping oldest: D displaces A
    step(1'b0, 1'b0, 1'b1, 1'b0, fd);
    check("t6_overflow", 128'(o_overflow), 128'd1);
    check("t6_count", 128'(o_count), 128'd3);
    check("t6_head_b", o_r_data, fb);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("t6_head_c", o_r_data, fc);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("t6_head_d", o_r_data, fd);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
`endif
    check("t1_drained", 128'(o_empty), 128'd1);

    // Wrap-around with interleaved write/read
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, DATA_W'(i));
      check("t2_head", o_r_data, 128'(i));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    end

    // Full with simultaneous read/write
    step(1'b0, 1'b0, 1'b1, 1'b0, fa);
    step(1'b0, 1'b0, 1'b1, 1'b0, fb);
    step(1'b0, 1'b0, 1'b1, 1'b0, fc);
    step(1'b0, 1'b0, 1'b1, 1'b1, fd);
    check("t3_count", 128'(o_count), 128'd3);
    check("t3_no_overflow", 128'(o_overflow), 128'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("t3_d_last", o_r_data, fd);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Empty with simultaneous read/write
    step(1'b0, 1'b0, 1'b1, 1'b1, 128'h55);
    check("t4_underflow", 128'(o_underflow), 128'd1);
    check("t4_r_data", o_r_data, 128'h55);
    check("t4_count", 128'(o_count), 128'd1);

    // Flush with a concurrent write, then reset mid-burst
    step(1'b0, 1'b0, 1'b1, 1'b0, fb);
    step(1'b0, 1'b1, 1'b1, 1'b0, fc);
    check("t5_flush_count", 128'(o_count), 128'd0);
    check("t5_flush_r_data", o_r_data, 128'd0);
    check("t5_flush_no_ovf", 128'(o_overflow), 128'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, fa);
    step(1'b0, 1'b0, 1'b1, 1'b0, fb);
    step(1'b1, 1'b0, 1'b1, 1'b1, fc);
    check("t5_reset_count", 128'(o_count), 128'd0);
    check("t5_reset_empty", 128'(o_empty), 128'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom, $urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/can_param_fifo.md
Name: can_param_fifo

Overview:
Synchronous single-clock message FIFO for the CAN controller, next generation of the 128-bit frame buffer.
- Generalised: data width, and any depth ≥2 (non-power-of-two allowed).
- Adds: occupancy count, programmable almost-full/almost-empty flags, synchronous flush, simultaneous read/write when full.
- Sits between the bit-stream/frame assembler and the host register interface, for both TX and RX queues.

Parameters:
DATA_W, 128, width of one stored entry (one CAN frame record)
DEPTH, 4, number of entries; any integer ≥2
AF_THRESH, DEPTH-1, o_almost_full asserted when count ≥ AF_THRESH (1..DEPTH)
AE_THRESH, 1, o_almost_empty asserted when count ≤ AE_THRESH (0..DEPTH-1)
CNT_W, $clog2(DEPTH+1), derived; width of the count output

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_flush  in  1  synchronous clear of contents; one-cycle pulse
i_w_en  in  1  write request
i_w_data  in  DATA_W  write data
i_r_en  in  1  read request (pops the head entry)
o_r_data  out  DATA_W  head entry (show-ahead); 0 when empty
o_count  out  CNT_W  current occupancy 0..DEPTH
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count ≥ AF_THRESH
o_almost_empty  out  1  count ≤ AE_THRESH
o_overflow  out  1  one-cycle pulse: write rejected (or entry dropped, see option)
o_underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- State: w_ptr and r_ptr range 0..DEPTH-1 and wrap DEPTH-1 → 0 (explicit compare, not a power-of-two mask); count register 0..DEPTH.
- Memory array is not reset.
- All flags are derived combinationally from count.
- Reset:
  - w_ptr = r_ptr = count = 0.
  - o_overflow = o_underflow = 0.
  - Outputs after reset: o_empty = 1, o_full = 0, o_r_data = 0, o_count = 0, o_almost_empty = 1, o_almost_full = (AF_THRESH == 0 ? 1 : 0).
- Priority: i_reset > i_flush > read/write.
- Flush:
  - Pointers and count go to 0; both error pulses go to 0.
  - w_en and r_en that cycle are ignored; no error flagged.
- Read accept: i_r_en && !o_empty. r_ptr advances next edge; o_r_data shows the new head combinationally.
- Write accept: i_w_en && (!o_full || read accepted the same cycle). Data goes to memory[w_ptr]; w_ptr advances.
- Count: +1 on write only, −1 on read only, unchanged on both.
- Simultaneous events:
  - Empty + w_en + r_en: write accepted, read rejected, o_underflow pulses, count → 1.
  - Full + w_en + r_en: both accepted, count stays DEPTH, no overflow.
- Errors:
  - o_overflow = 1 for exactly the cycle after a rejected write.
  - o_underflow = 1 for exactly the cycle after a rejected read.
  - Both are otherwise 0; they are not sticky.
- Read latency: data written at edge N is visible on o_r_data after edge N when the FIFO was empty (no bypass within the same cycle).

Optional Feature:
Macro: CAN_FIFO_DROP_OLDEST_EN
- Defined: a write while full with no read overwrites the oldest entry.
  - memory[w_ptr] is written, and both w_ptr and r_ptr advance.
  - Count stays DEPTH.
  - o_overflow still pulses to signal data loss.
  - Used for RX queues, where the newest frame wins.
- Not defined: a write while full with no read is discarded; pointers are unchanged and o_overflow pulses.

Decomposition:
- Shared package can_pkg:
  - localparam CAN_FRAME_W = 128.
  - typedef logic [CAN_FRAME_W-1:0] can_frame_t.
  - Helper function next_ptr(ptr, depth) for wrap-around increment.
- Sub-module can_wrap_ptr: parameter DEPTH; inputs clk, reset, clear, inc; output ptr. Instantiated twice (write and read pointer).
- Count, flags and memory stay in the top module.

Test Plan:
1. DEPTH=3, AF_THRESH=2, AE_THRESH=1: write A, B, C.
   - Count goes 1, 2, 3; o_almost_full at count 2; o_full at 3.
   - 4th write → o_overflow pulses one cycle; reading 3 times returns A, B, C.
2. Wrap-around with DEPTH=3: 7 interleaved write/read pairs with data 0x1..0x7.
   - Read order is 0x1..0x7; count never exceeds 2; no error pulses.
3. Full (count=3): w_en=r_en=1 with data D.
   - Head popped, count stays 3, no overflow; D is read last.
4. Empty: w_en=r_en=1 with data 0x55.
   - o_underflow pulses; count → 1; o_r_data = 0x55 next cycle.
5. Count=2, then i_flush with w_en=1 the same cycle.
   - Next cycle: count=0, o_empty=1, o_r_data=0, no overflow.
   - Also assert i_reset mid-burst → identical cleared state.
6. With CAN_FIFO_DROP_OLDEST_EN, DEPTH=3 holding A, B, C: write D.
   - o_overflow pulses; count=3; reads return B, C, D.
